// File: rtl/pcs_tx_encoder_pipe.sv
// ---------------------------------------------------------------------------
// pcs_tx_encoder_pipe
//
// Two-stage 64b/66b transmit encoder for NUM_CH independent 10GBASE-R style
// channels. It sits between the XGMII buffer and the scrambler/gearbox.
// Stage 1 registers the XGMII word and classifies it per channel (D/S/O/C/Tk/E).
// Stage 2 runs the per-channel TX state machine and registers the 66-bit
// block. Any block that the state machine rejects is replaced by an error
// block.
//
// Optional feature macro: PCS_ERR_CNT_EN
//   defined   : per-channel 16-bit saturating error-block counters.
//   undefined : err_cnt is tied to zero, err_cnt_clr is ignored.
//
// Ports
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   in_valid     input word valid (all channels together)
//   in_ready     encoder accepts input this cycle
//   enc_in       per channel c, [72c+71:72c]: [7:0] ctrl, [8i+15:8i+8] lane i
//   out_valid    encoded blocks valid
//   out_ready    downstream accepts blocks
//   enc_out      per channel c, [66c+65:66c]: [1:0] sync, [65:2] payload
//   err_cnt      per-channel error-block count, [16c+15:16c]
//   err_cnt_clr  synchronous clear of all err_cnt
// ---------------------------------------------------------------------------
module pcs_tx_encoder_pipe #(
    parameter int         NUM_CH    = 1,
    parameter logic [7:0] IDLE_CHAR = 8'h07,
    parameter logic [7:0] ERR_CHAR  = 8'hFE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [72*NUM_CH-1:0] enc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [66*NUM_CH-1:0] enc_out,
    output logic [16*NUM_CH-1:0] err_cnt,
    input  logic                 err_cnt_clr
);

    typedef enum logic [2:0] {CLS_D, CLS_S, CLS_O, CLS_C, CLS_T, CLS_E} cls_e;
    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;

    typedef struct packed {
        cls_e       cls;
        logic [2:0] k;      // terminate lane position, only meaningful for CLS_T
    } cls_t;

    localparam logic [65:0] ERR_BLOCK = {{8{7'h1E}}, 8'h1E, 2'b01};

    function automatic logic is_idle_or_err(input logic [7:0] b);
        return (b == IDLE_CHAR) || (b == ERR_CHAR);
    endfunction

    // Control lanes reaching the encoder are always idle or error.
    function automatic logic [6:0] ctl_code(input logic [7:0] b);
        return (b == ERR_CHAR) ? 7'h1E : 7'h00;
    endfunction

    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        case (k)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

    function automatic cls_t classify(input logic [71:0] w);
        cls_t        res;
        logic [7:0]  ctrl;
        logic [63:0] d;
        logic        all_ic;
        logic        hit;
        ctrl    = w[7:0];
        d       = w[71:8];
        res.cls = CLS_E;
        res.k   = 3'd0;
        all_ic  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!is_idle_or_err(d[8*i +: 8])) all_ic = 1'b0;
        end
        if (ctrl == 8'h00) begin
            res.cls = CLS_D;
        end else if (ctrl == 8'h01 && d[7:0] == 8'hFB) begin
            res.cls = CLS_S;
        end else if (ctrl == 8'h01 && (d[7:0] == 8'h9C || d[7:0] == 8'h5C)) begin
            res.cls = CLS_O;
        end else if (ctrl == 8'hFF && all_ic) begin
            res.cls = CLS_C;
        end else begin
            // Terminate in lane j: ctrl marks lanes j..7, lane j is FD and
            // every lane after it is idle or error.
            for (int j = 0; j < 8; j++) begin
                hit = (ctrl == (8'hFF << j)) && (d[8*j +: 8] == 8'hFD);
                for (int i = j + 1; i < 8; i++) begin
                    if (!is_idle_or_err(d[8*i +: 8])) hit = 1'b0;
                end
                if (hit) begin
                    res.cls = CLS_T;
                    res.k   = 3'(j);
                end
            end
        end
        return res;
    endfunction

    function automatic logic [65:0] encode(input cls_t ci, input logic [63:0] d);
        logic [63:0] p;
        logic [1:0]  sync;
        int          k;
        p    = '0;
        sync = 2'b01;
        k    = int'(ci.k);
        case (ci.cls)
            CLS_D: begin
                sync = 2'b10;
                p    = d;
            end
            CLS_S: p = {d[63:8], 8'h78};
            CLS_O: p = {28'h0, (d[7:0] == 8'h5C) ? 4'hF : 4'h0, d[31:8], 8'h4B};
            CLS_C: begin
                p[7:0] = 8'h1E;
                for (int i = 0; i < 8; i++) p[8+7*i +: 7] = ctl_code(d[8*i +: 8]);
            end
            CLS_T: begin
                // Data bytes sit right after the type; codes for lanes past
                // the terminate keep their control-block positions, so the
                // gap between them is the zero pad.
                p[7:0] = term_type(ci.k);
                for (int i = 0; i < 7; i++) begin
                    if (i < k) p[8+8*i +: 8] = d[8*i +: 8];
                end
                for (int i = 1; i < 8; i++) begin
                    if (i > k) p[8+7*i +: 7] = ctl_code(d[8*i +: 8]);
                end
            end
            default: p = ERR_BLOCK[65:2];
        endcase
        return {p, sync};
    endfunction

    function automatic tx_state_e next_state(input tx_state_e s, input cls_e c);
        tx_state_e ns;
        ns = TX_E;
        case (s)
            TX_D: begin
                if (c == CLS_D)      ns = TX_D;
                else if (c == CLS_T) ns = TX_T;
            end
            TX_E: begin
                // A start is only legal once a control block has been seen.
                if (c == CLS_D)                      ns = TX_D;
                else if (c == CLS_T)                 ns = TX_T;
                else if (c == CLS_C || c == CLS_O)   ns = TX_C;
            end
            default: begin
                if (c == CLS_C || c == CLS_O) ns = TX_C;
                else if (c == CLS_S)          ns = TX_D;
            end
        endcase
        return ns;
    endfunction

    // Shared handshake control
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_load;
    logic s1_load;
    logic s2_fire;

    assign s2_load   = ~out_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s2_load;
    assign s1_load   = in_ready & in_valid;
    assign s2_fire   = s2_load & s1_valid_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (in_ready) s1_valid_q  <= in_valid;
            if (s2_load)  out_valid_q <= s1_valid_q;
        end
    end

`ifndef PCS_ERR_CNT_EN
    logic unused_err_cnt_clr;
    assign unused_err_cnt_clr = err_cnt_clr;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [63:0] s1_data_q;
        cls_t        s1_cls_q;
        tx_state_e   state_q;
        tx_state_e   state_d;
        logic        emit_err;
        logic [65:0] enc_q;
        logic [65:0] enc_d;

        // ---- Stage 1: register word and its block class ----
        always_ff @(posedge clk) begin
            if (s1_load) begin
                s1_data_q <= enc_in[72*c+8 +: 64];
                s1_cls_q  <= classify(enc_in[72*c +: 72]);
            end
        end

        // ---- Stage 2: state machine and block encoding ----
        always_comb begin
            state_d  = next_state(state_q, s1_cls_q.cls);
            emit_err = (state_d == TX_E);
            enc_d    = emit_err ? ERR_BLOCK : encode(s1_cls_q, s1_data_q);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= TX_INIT;
                enc_q   <= '0;
            end else if (s2_fire) begin
                state_q <= state_d;
                enc_q   <= enc_d;
            end
        end

        assign enc_out[66*c +: 66] = enc_q;

`ifdef PCS_ERR_CNT_EN
        logic [15:0] err_cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_cnt_q <= '0;
            end else if (err_cnt_clr) begin
                err_cnt_q <= '0;
            end else if (s2_fire && emit_err && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end

        assign err_cnt[16*c +: 16] = err_cnt_q;
`else
        assign err_cnt[16*c +: 16] = 16'h0000;
`endif
    end

endmodule
